// File: rtl/vga_timing_decoder_if.sv
// Sync-side bundle of the VGA timing decoder: sampled sync inputs in, recovered timing and status out.
// dbg_state exposes the lock FSM (0 SEARCH, 1 ACQUIRE, 2 LOCKED).
interface vga_timing_decoder_if;
    logic       pix_ce;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] hCount_rx;
    logic [9:0] vCount_rx;
    logic       bright_rx;
    logic       locked;
    logic       frame_pulse;
    logic       h_err;
    logic       v_err;
    logic [7:0] err_count;
    logic [1:0] dbg_state;

    modport master (
        output pix_ce, hsync_in, vsync_in,
        input  hCount_rx, vCount_rx, bright_rx, locked, frame_pulse,
        input  h_err, v_err, err_count, dbg_state
    );

    modport slave (
        input  pix_ce, hsync_in, vsync_in,
        output hCount_rx, vCount_rx, bright_rx, locked, frame_pulse,
        output h_err, v_err, err_count, dbg_state
    );
endinterface

// File: rtl/vga_timing_decoder.sv
// Rebuilds VGA pixel/line counters from hSync/vSync alone, checks them against nominal
// timing, and tracks lock over consecutive clean frames.
module vga_timing_decoder #(
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_VIS_START = 144,
    parameter int H_VIS_END   = 783,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_VIS_START = 35,
    parameter int V_VIS_END   = 514,
    parameter int LOCK_FRAMES = 2
) (
    input logic             clk,
    input logic             reset,
    vga_timing_decoder_if.slave bus
);
    localparam int GW = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH = 2'd0, ACQUIRE = 2'd1, LOCKED = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [GW-1:0]  good_q, good_d;
    logic           hs_q, hs_d, vs_q, vs_d;
    logic [9:0]     hcnt_q, hcnt_d, vcnt_q, vcnt_d, vcnt_inc;
    logic           bright_q, bright_d;
    logic           fp_q, fp_d;
    logic           herr_q, verr_q;
    logic [7:0]     errc_q, errc_d;
    logic           h_fall, h_rise, v_fall, v_rise;
    logic           checking, h_viol, v_viol, any_err;

    always_comb begin
        h_fall   = bus.pix_ce & hs_q & ~bus.hsync_in;
        h_rise   = bus.pix_ce & ~hs_q & bus.hsync_in;
        v_fall   = bus.pix_ce & vs_q & ~bus.vsync_in;
        v_rise   = bus.pix_ce & ~vs_q & bus.vsync_in;
        vcnt_inc = (vcnt_q == 10'd1023) ? vcnt_q : vcnt_q + 10'd1;
        checking = (state_q != SEARCH);
        // The last term fires on the single step that takes hCount into saturation.
        h_viol   = checking &
                   ((h_fall && hcnt_q != 10'(H_TOTAL - 1)) ||
                    (h_rise && hcnt_q != 10'(H_SYNC - 1)) ||
                    (bus.pix_ce && !h_fall && hcnt_q == 10'd1022));
        // vSync rises on the h_fall that opens line V_SYNC, so compare the line being entered.
        v_viol   = checking &
                   ((v_fall && (!h_fall || vcnt_q != 10'(V_TOTAL - 1))) ||
                    (v_rise && (!h_fall || vcnt_inc != 10'(V_SYNC))));
        any_err  = h_viol | v_viol;
    end

    always_comb begin
        hs_d   = bus.pix_ce ? bus.hsync_in : hs_q;
        vs_d   = bus.pix_ce ? bus.vsync_in : vs_q;
        hcnt_d = hcnt_q;
        if (h_fall)
            hcnt_d = 10'd0;
        else if (bus.pix_ce && hcnt_q != 10'd1023)
            hcnt_d = hcnt_q + 10'd1;
        vcnt_d = vcnt_q;
        if (h_fall)
            vcnt_d = v_fall ? 10'd0 : vcnt_inc;
        bright_d = (state_d == LOCKED) &&
                   hcnt_d >= 10'(H_VIS_START) && hcnt_d <= 10'(H_VIS_END) &&
                   vcnt_d >= 10'(V_VIS_START) && vcnt_d <= 10'(V_VIS_END);
        errc_d = (any_err && errc_q != 8'd255) ? errc_q + 8'd1 : errc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SEARCH;
            good_q  <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            SEARCH: begin
                if (v_fall && h_fall) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (any_err) begin
                    state_d = SEARCH;
                end else if (v_fall) begin
                    good_d = good_q + GW'(1);
                    if (good_d == GW'(LOCK_FRAMES))
                        state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (any_err)
                    state_d = SEARCH;
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        fp_d            = (state_q == LOCKED) & v_fall & ~any_err;
        bus.locked      = (state_q == LOCKED);
        bus.dbg_state   = state_q;
        bus.hCount_rx   = hcnt_q;
        bus.vCount_rx   = vcnt_q;
        bus.bright_rx   = bright_q;
        bus.frame_pulse = fp_q;
        bus.h_err       = herr_q;
        bus.v_err       = verr_q;
        bus.err_count   = errc_q;
    end

    // Sync history resets high so a line already in progress cannot fake a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            hcnt_q   <= '0;
            vcnt_q   <= '0;
            bright_q <= 1'b0;
            fp_q     <= 1'b0;
            herr_q   <= 1'b0;
            verr_q   <= 1'b0;
            errc_q   <= '0;
        end else begin
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            hcnt_q   <= hcnt_d;
            vcnt_q   <= vcnt_d;
            bright_q <= bright_d;
            fp_q     <= fp_d;
            herr_q   <= h_viol;
            verr_q   <= v_viol;
            errc_q   <= errc_d;
        end
    end
endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder using a scaled-down raster so whole frames stay short.
module tb_vga_timing_decoder;
  localparam int H_TOTAL     = 40;
  localparam int H_SYNC      = 6;
  localparam int H_VIS_START = 10;
  localparam int H_VIS_END   = 33;
  localparam int V_TOTAL     = 12;
  localparam int V_SYNC      = 2;
  localparam int V_VIS_START = 3;
  localparam int V_VIS_END   = 9;
  localparam int VIS_PIX     = (H_VIS_END - H_VIS_START + 1) * (V_VIS_END - V_VIS_START + 1);

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vga_timing_decoder_if bus();

  vga_timing_decoder #(
    .H_TOTAL(H_TOTAL), .H_SYNC(H_SYNC), .H_VIS_START(H_VIS_START), .H_VIS_END(H_VIS_END),
    .V_TOTAL(V_TOTAL), .V_SYNC(V_SYNC), .V_VIS_START(V_VIS_START), .V_VIS_END(V_VIS_END),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic [19:0] exp_q[$];
  bit exp_locked = 1'b0;
  int cur_line, cur_pix;
  int herr_line = -9, herr_pix = -9, verr_line = -9, verr_pix = -9;
  logic lock_at_herr = 1'b1;
  int bright_tot = 0;
  int h_err_tot = 0, v_err_tot = 0, both_tot = 0, fp_tot = 0;
  int h0, v0, b0, f0, br0;

  // Pulse totals sampled on the falling edge; a pulse held too long is counted twice.
  always @(negedge clk) begin
    if (bus.h_err) h_err_tot++;
    if (bus.v_err) v_err_tot++;
    if (bus.h_err && bus.v_err) both_tot++;
    if (bus.frame_pulse) fp_tot++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One pix_ce sample followed by one idle clock.
  task automatic tx_sample(input bit hs, input bit vs);
    @(negedge clk);
    bus.pix_ce = 1'b1;
    bus.hsync_in = hs;
    bus.vsync_in = vs;
    @(posedge clk);
    #1;
    if (bus.bright_rx) bright_tot++;
    if (bus.h_err) begin
      herr_line = cur_line;
      herr_pix = cur_pix;
      lock_at_herr = bus.locked;
    end
    if (bus.v_err) begin
      verr_line = cur_line;
      verr_pix = cur_pix;
    end
    @(negedge clk);
    bus.pix_ce = 1'b0;
    @(posedge clk);
  endtask

  task automatic send_frame(input bit track, input bit lock_start, input int long_at,
                            input int short_at, input int vs_len, input bit vs_late,
                            input int n_lines);
    for (int l = 0; l < n_lines; l++) begin
      int len, hsw;
      len = (l == long_at) ? H_TOTAL + 1 : H_TOTAL;
      hsw = (l == short_at) ? H_SYNC - 1 : H_SYNC;
      for (int p = 0; p < len; p++) begin
        bit hs, vs, exp_b;
        logic [19:0] e;
        hs = (p >= hsw);
        vs = !(l < vs_len);
        if (vs_late && l == 0 && p == 0) vs = 1'b1;
        if (lock_start && l == 0 && p == 0) exp_locked = 1'b1;
        cur_line = l;
        cur_pix = p;
        if (track) exp_q.push_back({10'(p), 10'(l)});
        tx_sample(hs, vs);
        if (track) begin
          e = exp_q.pop_front();
          exp_b = exp_locked && p >= H_VIS_START && p <= H_VIS_END &&
                  l >= V_VIS_START && l <= V_VIS_END;
          check("hv_count", {12'd0, bus.hCount_rx, bus.vCount_rx}, {12'd0, e});
          check("bright", {31'd0, bus.bright_rx}, {31'd0, exp_b});
          check("locked_track", {31'd0, bus.locked}, {31'd0, exp_locked});
        end
      end
    end
  endtask

  task automatic nom(input bit track, input bit lock_start);
    send_frame(track, lock_start, -1, -1, V_SYNC, 1'b0, V_TOTAL);
  endtask

  task automatic relock();
    exp_locked = 1'b0;
    nom(1'b1, 1'b0);
    nom(1'b1, 1'b0);
    nom(1'b1, 1'b1);
    check("relocked", {31'd0, bus.locked}, 32'd1);
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_hcount"}, {22'd0, bus.hCount_rx}, 32'd0);
    check({pfx, "_vcount"}, {22'd0, bus.vCount_rx}, 32'd0);
    check({pfx, "_bright"}, {31'd0, bus.bright_rx}, 32'd0);
    check({pfx, "_locked"}, {31'd0, bus.locked}, 32'd0);
    check({pfx, "_frame_pulse"}, {31'd0, bus.frame_pulse}, 32'd0);
    check({pfx, "_h_err"}, {31'd0, bus.h_err}, 32'd0);
    check({pfx, "_v_err"}, {31'd0, bus.v_err}, 32'd0);
    check({pfx, "_err_count"}, {24'd0, bus.err_count}, 32'd0);
    check({pfx, "_state"}, {30'd0, bus.dbg_state}, 32'd0);
  endtask

  task automatic snap();
    h0 = h_err_tot; v0 = v_err_tot; b0 = both_tot; f0 = fp_tot; br0 = bright_tot;
  endtask

  initial begin
    bus.pix_ce = 1'b0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Nominal raster: lock after the third vsync fall, then steady frame pulses.
    snap();
    nom(1'b1, 1'b0);
    nom(1'b1, 1'b0);
    check("no_lock_yet", {31'd0, bus.locked}, 32'd0);
    nom(1'b1, 1'b1);
    check("frame_pulse_lock_frame", fp_tot - f0, 32'd0);
    snap();
    nom(1'b1, 1'b0);
    check("frame_pulse_1", fp_tot - f0, 32'd1);
    check("bright_pixels", bright_tot - br0, VIS_PIX);
    nom(1'b1, 1'b0);
    check("frame_pulse_2", fp_tot - f0, 32'd2);
    check("nominal_h_err", h_err_tot, 32'd0);
    check("nominal_v_err", v_err_tot, 32'd0);
    check("nominal_err_count", {24'd0, bus.err_count}, 32'd0);

    // One line one pixel too long.
    snap();
    send_frame(1'b0, 1'b0, 5, -1, V_SYNC, 1'b0, V_TOTAL);
    check("long_h_err", h_err_tot - h0, 32'd1);
    check("long_v_err", v_err_tot - v0, 32'd0);
    check("long_err_line", herr_line, 32'd6);
    check("long_err_pix", herr_pix, 32'd0);
    check("long_locked_drop", {31'd0, lock_at_herr}, 32'd0);
    check("long_err_count", {24'd0, bus.err_count}, 32'd1);
    check("long_state", {30'd0, bus.dbg_state}, 32'd0);
    relock();
    check("long_err_count_kept", {24'd0, bus.err_count}, 32'd1);

    // hSync one pixel short.
    snap();
    send_frame(1'b0, 1'b0, -1, 4, V_SYNC, 1'b0, V_TOTAL);
    check("short_h_err", h_err_tot - h0, 32'd1);
    check("short_v_err", v_err_tot - v0, 32'd0);
    check("short_err_line", herr_line, 32'd4);
    check("short_err_pix", herr_pix, H_SYNC - 1);
    check("short_state", {30'd0, bus.dbg_state}, 32'd0);
    check("short_err_count", {24'd0, bus.err_count}, 32'd2);
    relock();

    // vSync low for one extra line.
    snap();
    send_frame(1'b0, 1'b0, -1, -1, V_SYNC + 1, 1'b0, V_TOTAL);
    check("vlong_v_err", v_err_tot - v0, 32'd1);
    check("vlong_h_err", h_err_tot - h0, 32'd0);
    check("vlong_err_line", verr_line, V_SYNC + 1);
    check("vlong_err_pix", verr_pix, 32'd0);
    check("vlong_locked", {31'd0, bus.locked}, 32'd0);
    check("vlong_err_count", {24'd0, bus.err_count}, 32'd3);
    relock();

    // vSync falls one pixel after hSync.
    snap();
    send_frame(1'b0, 1'b0, -1, -1, V_SYNC, 1'b1, V_TOTAL);
    check("vlate_v_err", v_err_tot - v0, 32'd1);
    check("vlate_h_err", h_err_tot - h0, 32'd0);
    check("vlate_err_line", verr_line, 32'd0);
    check("vlate_err_pix", verr_pix, 32'd1);
    check("vlate_err_count", {24'd0, bus.err_count}, 32'd4);
    relock();

    // hSync stuck high until hCount saturates.
    snap();
    for (int i = 0; i < 1100; i++) begin
      cur_line = -1;
      cur_pix = i;
      tx_sample(1'b1, 1'b1);
    end
    check("hold_h_err", h_err_tot - h0, 32'd1);
    check("hold_v_err", v_err_tot - v0, 32'd0);
    check("hold_err_pix", herr_pix, 1023 - H_TOTAL);
    check("hold_hcount_sat", {22'd0, bus.hCount_rx}, 32'd1023);
    check("hold_locked", {31'd0, bus.locked}, 32'd0);
    check("hold_err_count", {24'd0, bus.err_count}, 32'd5);
    relock();

    // Reset mid-frame while locked, with a coincident sync fall on the same clock.
    send_frame(1'b1, 1'b0, -1, -1, V_SYNC, 1'b0, 5);
    check("pre_reset_locked", {31'd0, bus.locked}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    bus.pix_ce = 1'b1;
    bus.hsync_in = 1'b0;
    bus.vsync_in = 1'b0;
    @(posedge clk);
    #1;
    check_zero("midreset");
    @(negedge clk);
    reset = 1'b0;
    bus.pix_ce = 1'b0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    exp_locked = 1'b0;
    nom(1'b1, 1'b0);
    check("post_reset_state", {30'd0, bus.dbg_state}, 32'd1);
    check("post_reset_err_count", {24'd0, bus.err_count}, 32'd0);

    // Rapid error injection: enter ACQUIRE, then break both syncs at once.
    snap();
    for (int i = 0; i < 100; i++) begin
      tx_sample(1'b0, 1'b0);
      tx_sample(1'b1, 1'b1);
    end
    check("inject_err_count_100", {24'd0, bus.err_count}, 32'd100);
    for (int i = 0; i < 200; i++) begin
      tx_sample(1'b0, 1'b0);
      tx_sample(1'b1, 1'b1);
    end
    check("inject_err_count_sat", {24'd0, bus.err_count}, 32'd255);
    check("inject_h_err", h_err_tot - h0, 32'd300);
    check("inject_v_err", v_err_tot - v0, 32'd300);
    check("inject_both", both_tot - b0, 32'd300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
